// File: rtl/asn_table_rx.sv
// asn_table_rx -- receive-side decoder for the DPR -> model_manager assignment
// stream. It passively watches mm_o / asn_opcode / dpr_pass, assembles each
// layer in a staging record, commits layers into a region table and tracks
// the model input/output regions. It also latches the first protocol error.
//
// Build option: define ASN_RANGE_CHECK_EN to check every captured region
// (end >= begin, same address space MSB), raising error 5 on failure.
// ADDR_SIZE macro sets the address width of mem_handle_t (default 32).
//
// Ports:
//   clk, rst_l            clock, asynchronous active-low reset
//   mm_o                  assignment command for this cycle
//   asn_opcode            layer opcode, sampled with ASN_LAYER
//   dpr_pass              region operand of the previous cycle's command
//   tbl_clr               synchronous clear of all state
//   rd_idx, rd_sel        table read index / region select (0..5)
//   rd_region, rd_opcode,
//   rd_present            registered read data for rd_idx / rd_sel
//   layer_count           number of committed layers
//   in_region, out_region model input / output regions
//   model_valid           model fully described (sticky)
//   err, err_code         sticky first protocol error and its code

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

package asn_pkg;
    localparam int unsigned ADDR_W = `ADDR_SIZE;

    typedef enum logic [3:0] {
        WAIT,
        ASN_LAYER,
        ASN_SCRATCH,
        ASN_SGRAD,
        ASN_WEIGHT,
        ASN_WGRAD,
        ASN_BIAS,
        ASN_BGRAD,
        ASN_INPUT,
        ASN_OUTPUT,
        ASN_MODEL
    } mm_state;

    typedef enum logic [2:0] {
        OP_NONE,
        LINEAR,
        RELU,
        MSE,
        SOFTMAX
    } layer_opcode;

    typedef struct packed {
        logic [ADDR_W-1:0] region_begin;
        logic [ADDR_W-1:0] region_end;
    } mem_handle_t;
endpackage

module asn_table_rx
    import asn_pkg::*;
#(
    parameter int unsigned MAX_LAYERS = 8,
    parameter int unsigned ADDR_SIZE  = ADDR_W
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  mm_state                              mm_o,
    input  layer_opcode                          asn_opcode,
    input  mem_handle_t                          dpr_pass,
    input  logic                                 tbl_clr,
    input  logic [$clog2(MAX_LAYERS)-1:0]        rd_idx,
    input  logic [2:0]                           rd_sel,
    output mem_handle_t                          rd_region,
    output layer_opcode                          rd_opcode,
    output logic [5:0]                           rd_present,
    output logic [$clog2(MAX_LAYERS+1)-1:0]      layer_count,
    output mem_handle_t                          in_region,
    output mem_handle_t                          out_region,
    output logic                                 model_valid,
    output logic                                 err,
    output logic [2:0]                           err_code
);

    localparam int unsigned IDX_W = $clog2(MAX_LAYERS);
    localparam int unsigned CNT_W = $clog2(MAX_LAYERS+1);
    localparam int unsigned HW    = 2 * ADDR_SIZE;
    localparam int unsigned NSLOT = 6;

    typedef enum logic {S_IDLE, S_OPEN} lstate_t;

    // Pending capture kind; values 0..5 double as staging slot numbers.
    typedef enum logic [2:0] {
        P_SCRATCH, P_SGRAD, P_WEIGHT, P_WGRAD, P_BIAS, P_BGRAD, P_INPUT, P_OUTPUT
    } pkind_t;

    lstate_t            state_q, state_d;
    logic               pend_vld_q, pend_vld_d;
    pkind_t             pend_kind_q, pend_kind_d;
    layer_opcode        stg_op_q, stg_op_d;
    logic [NSLOT-1:0]   stg_pres_q, stg_pres_d;
    logic [HW-1:0]      stg_reg_q [NSLOT];
    logic [HW-1:0]      stg_reg_d [NSLOT];
    logic [NSLOT-1:0]   cap_pres;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mem_handle_t        in_q, in_d, out_q, out_d;
    logic               in_pres_q, in_pres_d, out_pres_q, out_pres_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [2:0]         code_q, code_d;
    logic               err_hit;
    logic [2:0]         err_new;

    logic               commit_en;
    logic [IDX_W-1:0]   commit_idx;

    layer_opcode        tbl_op_q   [MAX_LAYERS];
    logic [NSLOT-1:0]   tbl_pres_q [MAX_LAYERS];
    logic [HW-1:0]      tbl_reg_q  [MAX_LAYERS][NSLOT];

    mem_handle_t        rd_region_q, rd_region_d;
    layer_opcode        rd_op_q, rd_op_d;
    logic [NSLOT-1:0]   rd_pres_q, rd_pres_d;

`ifdef ASN_RANGE_CHECK_EN
    logic range_bad;
    assign range_bad = (dpr_pass.region_end < dpr_pass.region_begin) ||
                       (dpr_pass.region_begin[ADDR_SIZE-1] != dpr_pass.region_end[ADDR_SIZE-1]);
`endif

    assign commit_idx = cnt_q[IDX_W-1:0];

    // Command decode. The capture of the previous command's operand is
    // applied first so that a same-cycle ASN_MODEL commits it, and so that
    // capture errors rank ahead of command errors for "first error" purposes.
    always_comb begin
        state_d     = state_q;
        pend_vld_d  = 1'b0;
        pend_kind_d = pend_kind_q;
        stg_op_d    = stg_op_q;
        cap_pres    = stg_pres_q;
        stg_reg_d   = stg_reg_q;
        in_d        = in_q;
        out_d       = out_q;
        in_pres_d   = in_pres_q;
        out_pres_d  = out_pres_q;
        cnt_d       = cnt_q;
        commit_en   = 1'b0;
        err_hit     = 1'b0;
        err_new     = '0;

        if (pend_vld_q) begin
            if (pend_kind_q == P_INPUT) begin
                in_d      = dpr_pass;
                in_pres_d = 1'b1;
            end else if (pend_kind_q == P_OUTPUT) begin
                out_d      = dpr_pass;
                out_pres_d = 1'b1;
            end else begin
                for (int unsigned s = 0; s < NSLOT; s++) begin
                    if (32'(pend_kind_q) == s) begin
                        stg_reg_d[s] = dpr_pass;
                        cap_pres[s]  = 1'b1;
                    end
                end
            end
`ifdef ASN_RANGE_CHECK_EN
            if (range_bad && !err_hit) begin
                err_hit = 1'b1;
                err_new = 3'd5;
            end
`endif
        end

        stg_pres_d = cap_pres;

        unique case (mm_o)
            ASN_LAYER: begin
                if (state_q == S_OPEN && !err_hit) begin
                    err_hit = 1'b1;
                    err_new = 3'd1;
                end
                state_d    = S_OPEN;
                stg_op_d   = asn_opcode;
                stg_pres_d = '0;
            end
            ASN_SCRATCH, ASN_SGRAD, ASN_WEIGHT, ASN_WGRAD, ASN_BIAS, ASN_BGRAD: begin
                if (state_q == S_OPEN) begin
                    pend_vld_d  = 1'b1;
                    pend_kind_d = pkind_t'(3'(mm_o - ASN_SCRATCH));
                end else if (!err_hit) begin
                    err_hit = 1'b1;
                    err_new = 3'd2;
                end
            end
            ASN_INPUT: begin
                pend_vld_d  = 1'b1;
                pend_kind_d = P_INPUT;
            end
            ASN_OUTPUT: begin
                pend_vld_d  = 1'b1;
                pend_kind_d = P_OUTPUT;
            end
            ASN_MODEL: begin
                if (state_q == S_OPEN) begin
                    state_d = S_IDLE;
                    if (32'(cnt_q) == MAX_LAYERS) begin
                        if (!err_hit) begin
                            err_hit = 1'b1;
                            err_new = 3'd4;
                        end
                    end else begin
                        commit_en = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        if ((!cap_pres[0] || !cap_pres[1]) && !err_hit) begin
                            err_hit = 1'b1;
                            err_new = 3'd3;
                        end
                    end
                end
            end
            default: ;
        endcase

        err_d  = err_q | err_hit;
        code_d = (!err_q && err_hit) ? err_new : code_q;

        valid_d = valid_q | (in_pres_d & out_pres_d & (cnt_d != '0) & (state_d == S_IDLE));

        // Registered read port; uncommitted entries and absent slots read as 0.
        rd_pres_d   = '0;
        rd_op_d     = OP_NONE;
        rd_region_d = '0;
        for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
            if (32'(rd_idx) == i && i < 32'(cnt_q)) begin
                rd_pres_d = tbl_pres_q[i];
                rd_op_d   = tbl_op_q[i];
                for (int unsigned s = 0; s < NSLOT; s++) begin
                    if (32'(rd_sel) == s && tbl_pres_q[i][s]) begin
                        rd_region_d = mem_handle_t'(tbl_reg_q[i][s]);
                    end
                end
            end
        end

        if (tbl_clr) begin
            state_d     = S_IDLE;
            pend_vld_d  = 1'b0;
            stg_pres_d  = '0;
            cnt_d       = '0;
            in_d        = '0;
            out_d       = '0;
            in_pres_d   = 1'b0;
            out_pres_d  = 1'b0;
            valid_d     = 1'b0;
            err_d       = 1'b0;
            code_d      = '0;
            commit_en   = 1'b0;
            rd_pres_d   = '0;
            rd_op_d     = OP_NONE;
            rd_region_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            pend_vld_q  <= 1'b0;
            pend_kind_q <= P_SCRATCH;
            stg_op_q    <= OP_NONE;
            stg_pres_q  <= '0;
            cnt_q       <= '0;
            in_q        <= '0;
            out_q       <= '0;
            in_pres_q   <= 1'b0;
            out_pres_q  <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
            rd_region_q <= '0;
            rd_op_q     <= OP_NONE;
            rd_pres_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_kind_q <= pend_kind_d;
            stg_op_q    <= stg_op_d;
            stg_pres_q  <= stg_pres_d;
            cnt_q       <= cnt_d;
            in_q        <= in_d;
            out_q       <= out_d;
            in_pres_q   <= in_pres_d;
            out_pres_q  <= out_pres_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            code_q      <= code_d;
            rd_region_q <= rd_region_d;
            rd_op_q     <= rd_op_d;
            rd_pres_q   <= rd_pres_d;
        end
    end

    // Region payloads are qualified by present bits, so they need no reset.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NSLOT; s++) begin
            stg_reg_q[s] <= stg_reg_d[s];
        end
        if (commit_en) begin
            tbl_op_q[commit_idx] <= stg_op_q;
            for (int unsigned s = 0; s < NSLOT; s++) begin
                tbl_reg_q[commit_idx][s] <= stg_reg_d[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
                tbl_pres_q[i] <= '0;
            end
        end else if (tbl_clr) begin
            for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
                tbl_pres_q[i] <= '0;
            end
        end else if (commit_en) begin
            tbl_pres_q[commit_idx] <= cap_pres;
        end
    end

    assign rd_region   = rd_region_q;
    assign rd_opcode   = rd_op_q;
    assign rd_present  = rd_pres_q;
    assign layer_count = cnt_q;
    assign in_region   = in_q;
    assign out_region  = out_q;
    assign model_valid = valid_q;
    assign err         = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_asn_table_rx.sv
module tb_asn_table_rx;
    import asn_pkg::*;

    localparam int unsigned ML = 8;

    logic        clk = 1'b0;
    logic        rst_l;
    mm_state     mm_o;
    layer_opcode asn_opcode;
    mem_handle_t dpr_pass;
    logic        tbl_clr;
    logic [2:0]  rd_idx;
    logic [2:0]  rd_sel;
    mem_handle_t rd_region;
    layer_opcode rd_opcode;
    logic [5:0]  rd_present;
    logic [3:0]  layer_count;
    mem_handle_t in_region, out_region;
    logic        model_valid, err;
    logic [2:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;

    asn_table_rx #(.MAX_LAYERS(ML)) dut (
        .clk(clk), .rst_l(rst_l), .mm_o(mm_o), .asn_opcode(asn_opcode),
        .dpr_pass(dpr_pass), .tbl_clr(tbl_clr), .rd_idx(rd_idx), .rd_sel(rd_sel),
        .rd_region(rd_region), .rd_opcode(rd_opcode), .rd_present(rd_present),
        .layer_count(layer_count), .in_region(in_region), .out_region(out_region),
        .model_valid(model_valid), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        layer_opcode       op;
        logic [5:0]        pres;
        mem_handle_t [5:0] r;
    } layer_t;

    layer_t      m_tbl[$];
    layer_t      m_stg;
    bit          m_open, m_pend;
    int          m_pkind;
    mem_handle_t m_in, m_out;
    bit          m_in_p, m_out_p, m_valid, m_err;
    logic [2:0]  m_code;

    function automatic void m_clear();
        m_tbl.delete();
        m_stg = '0; m_open = 0; m_pend = 0; m_pkind = 0;
        m_in = '0; m_out = '0; m_in_p = 0; m_out_p = 0;
        m_valid = 0; m_err = 0; m_code = '0;
    endfunction

    function automatic void m_raise(input logic [2:0] c);
        if (!m_err) begin
            m_err  = 1;
            m_code = c;
        end
    endfunction

    function automatic void m_step(input bit clr, input mm_state cmd,
                                   input layer_opcode op, input mem_handle_t pass);
        if (clr) begin
            m_clear();
            return;
        end
        if (m_pend) begin
            if (m_pkind == 6) begin m_in = pass; m_in_p = 1; end
            else if (m_pkind == 7) begin m_out = pass; m_out_p = 1; end
            else begin m_stg.r[m_pkind] = pass; m_stg.pres[m_pkind] = 1'b1; end
`ifdef ASN_RANGE_CHECK_EN
            if (pass.region_end < pass.region_begin ||
                pass.region_begin[ADDR_W-1] != pass.region_end[ADDR_W-1])
                m_raise(3'd5);
`endif
        end
        m_pend = 0;
        case (cmd)
            ASN_LAYER: begin
                if (m_open) m_raise(3'd1);
                m_open = 1;
                m_stg = '0;
                m_stg.op = op;
            end
            ASN_SCRATCH, ASN_SGRAD, ASN_WEIGHT, ASN_WGRAD, ASN_BIAS, ASN_BGRAD: begin
                if (m_open) begin
                    m_pend  = 1;
                    m_pkind = int'(cmd) - int'(ASN_SCRATCH);
                end else m_raise(3'd2);
            end
            ASN_INPUT:  begin m_pend = 1; m_pkind = 6; end
            ASN_OUTPUT: begin m_pend = 1; m_pkind = 7; end
            ASN_MODEL: begin
                if (m_open) begin
                    m_open = 0;
                    if (m_tbl.size() == ML) m_raise(3'd4);
                    else begin
                        if (!m_stg.pres[0] || !m_stg.pres[1]) m_raise(3'd3);
                        m_tbl.push_back(m_stg);
                    end
                end
            end
            default: ;
        endcase
        if (m_in_p && m_out_p && m_tbl.size() > 0 && !m_open) m_valid = 1;
    endfunction

    function automatic void m_read(input logic [2:0] idx, input logic [2:0] sel,
                                   output mem_handle_t r, output layer_opcode o,
                                   output logic [5:0] p);
        r = '0; o = OP_NONE; p = '0;
        if (int'(idx) < m_tbl.size()) begin
            p = m_tbl[idx].pres;
            o = m_tbl[idx].op;
            if (int'(sel) < 6 && p[sel]) r = m_tbl[idx].r[sel];
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input mem_handle_t er, input layer_opcode eo, input logic [5:0] ep);
        chk("layer_count", 128'(layer_count), 128'(m_tbl.size()));
        chk("err",         128'(err),         128'(m_err));
        chk("err_code",    128'(err_code),    128'(m_code));
        chk("model_valid", 128'(model_valid), 128'(m_valid));
        chk("in_region",   128'(in_region),   128'(m_in));
        chk("out_region",  128'(out_region),  128'(m_out));
        chk("rd_region",   128'(rd_region),   128'(er));
        chk("rd_opcode",   128'(rd_opcode),   128'(eo));
        chk("rd_present",  128'(rd_present),  128'(ep));
    endtask

    function automatic mem_handle_t mh(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] e);
        mh.region_begin = b;
        mh.region_end   = e;
    endfunction

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic cycle(input bit clr, input mm_state cmd, input layer_opcode op,
                         input mem_handle_t pass, input logic [2:0] idx, input logic [2:0] sel);
        mem_handle_t er;
        layer_opcode eo;
        logic [5:0]  ep;
        tbl_clr = clr; mm_o = cmd; asn_opcode = op; dpr_pass = pass;
        rd_idx = idx; rd_sel = sel;
        m_read(idx, sel, er, eo, ep);
        if (clr) begin er = '0; eo = OP_NONE; ep = '0; end
        @(posedge clk);
        m_step(clr, cmd, op, pass);
        @(negedge clk);
        check_all(er, eo, ep);
    endtask

    task automatic cmd(input mm_state c, input mem_handle_t pass);
        cycle(1'b0, c, LINEAR, pass, 3'd0, 3'd0);
    endtask

    task automatic rd(input logic [2:0] idx, input logic [2:0] sel);
        cycle(1'b0, WAIT, OP_NONE, '0, idx, sel);
    endtask

    task automatic do_reset();
        rst_l = 1'b0; tbl_clr = 1'b0; mm_o = WAIT; asn_opcode = OP_NONE;
        dpr_pass = '0; rd_idx = '0; rd_sel = '0;
        m_clear();
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        mm_state           cmd;
        layer_opcode       op;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] e;
        logic [3:0]        cnt;
        logic              vld;
    } vec_t;

    function automatic vec_t mk(input mm_state c, input layer_opcode o,
                                input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] e,
                                input logic [3:0] n, input logic v);
        mk.cmd = c; mk.op = o; mk.b = b; mk.e = e; mk.cnt = n; mk.vld = v;
    endfunction

    vec_t vecs [19];

    initial begin
        // operand on each row belongs to the command of the row above
        vecs[0]  = mk(ASN_LAYER,   LINEAR,  0,   0,   4'd0, 1'b0);
        vecs[1]  = mk(ASN_SCRATCH, OP_NONE, 0,   0,   4'd0, 1'b0);
        vecs[2]  = mk(ASN_SGRAD,   OP_NONE, 42,  50,  4'd0, 1'b0);
        vecs[3]  = mk(ASN_WEIGHT,  OP_NONE, 50,  58,  4'd0, 1'b0);
        vecs[4]  = mk(ASN_WGRAD,   OP_NONE, 5,   34,  4'd0, 1'b0);
        vecs[5]  = mk(ASN_BIAS,    OP_NONE, 58,  87,  4'd0, 1'b0);
        vecs[6]  = mk(ASN_BGRAD,   OP_NONE, 34,  42,  4'd0, 1'b0);
        vecs[7]  = mk(ASN_MODEL,   OP_NONE, 87,  95,  4'd1, 1'b0);
        vecs[8]  = mk(ASN_LAYER,   RELU,    0,   0,   4'd1, 1'b0);
        vecs[9]  = mk(ASN_SCRATCH, OP_NONE, 0,   0,   4'd1, 1'b0);
        vecs[10] = mk(ASN_SGRAD,   OP_NONE, 95,  103, 4'd1, 1'b0);
        vecs[11] = mk(ASN_MODEL,   OP_NONE, 103, 111, 4'd2, 1'b0);
        vecs[12] = mk(ASN_LAYER,   MSE,     0,   0,   4'd2, 1'b0);
        vecs[13] = mk(ASN_SCRATCH, OP_NONE, 0,   0,   4'd2, 1'b0);
        vecs[14] = mk(ASN_SGRAD,   OP_NONE, 111, 119, 4'd2, 1'b0);
        vecs[15] = mk(ASN_MODEL,   OP_NONE, 119, 127, 4'd3, 1'b0);
        vecs[16] = mk(ASN_INPUT,   OP_NONE, 0,   0,   4'd3, 1'b0);
        vecs[17] = mk(ASN_OUTPUT,  OP_NONE, 32'h8000_0000, 32'h8000_0007, 4'd3, 1'b0);
        vecs[18] = mk(WAIT,        OP_NONE, 32'h8000_0007, 32'h8000_000E, 4'd3, 1'b1);

        // reset state
        do_reset();
        check_all('0, OP_NONE, '0);
        chk("reset_count", 128'(layer_count), 128'(0));
        chk("reset_valid", 128'(model_valid), 128'(0));

        // full model from the table
        for (int i = 0; i < 19; i++) begin
            cycle(1'b0, vecs[i].cmd, vecs[i].op, mh(vecs[i].b, vecs[i].e), 3'd0, 3'd0);
            chk($sformatf("vec%0d_count", i), 128'(layer_count), 128'(vecs[i].cnt));
            chk($sformatf("vec%0d_valid", i), 128'(model_valid), 128'(vecs[i].vld));
            chk($sformatf("vec%0d_err", i),   128'(err),         128'(1'b0));
        end
        rd(3'd0, 3'd2);
        chk("e0_weight", 128'(rd_region), 128'(mh(5, 34)));
        chk("e0_opcode", 128'(rd_opcode), 128'(LINEAR));
        rd(3'd1, 3'd0);
        chk("e1_present", 128'(rd_present), 128'(6'b000011));
        chk("e1_scratch", 128'(rd_region),  128'(mh(95, 103)));
        rd(3'd0, 3'd5);
        chk("e0_present", 128'(rd_present), 128'(6'b111111));
        chk("e0_bgrad",   128'(rd_region),  128'(mh(87, 95)));
        rd(3'd2, 3'd1);
        chk("e2_opcode", 128'(rd_opcode), 128'(MSE));
        chk("e2_sgrad",  128'(rd_region), 128'(mh(119, 127)));
        rd(3'd3, 3'd0);
        chk("e3_uncommitted", 128'(rd_present), 128'(6'b0));
        chk("in_region",  128'(in_region),  128'(mh(32'h8000_0000, 32'h8000_0007)));
        chk("out_region", 128'(out_region), 128'(mh(32'h8000_0007, 32'h8000_000E)));

        // nested ASN_LAYER keeps the second opcode
        do_reset();
        cycle(1'b0, ASN_LAYER, LINEAR, '0, 3'd0, 3'd0);
        cycle(1'b0, ASN_LAYER, RELU,   '0, 3'd0, 3'd0);
        chk("nest_err",  128'(err),      128'(1));
        chk("nest_code", 128'(err_code), 128'(1));
        cmd(ASN_SCRATCH, '0);
        cmd(ASN_SGRAD, mh(1, 2));
        cmd(ASN_MODEL, mh(2, 3));
        rd(3'd0, 3'd0);
        chk("nest_count",  128'(layer_count), 128'(1));
        chk("nest_opcode", 128'(rd_opcode),   128'(RELU));

        // layer pointer in IDLE
        do_reset();
        cmd(ASN_WEIGHT, '0);
        cmd(WAIT, mh(7, 9));
        chk("idle_code",  128'(err_code),    128'(2));
        chk("idle_count", 128'(layer_count), 128'(0));

        // table overflow on the 9th commit
        do_reset();
        for (int l = 0; l < 9; l++) begin
            cmd(ASN_LAYER, '0);
            cmd(ASN_SCRATCH, '0);
            cmd(ASN_SGRAD, mh(ADDR_W'(l * 16), ADDR_W'(l * 16 + 8)));
            cmd(ASN_MODEL, mh(ADDR_W'(l * 16 + 8), ADDR_W'(l * 16 + 16)));
            if (l == 7) begin
                chk("ovf_count8", 128'(layer_count), 128'(8));
                chk("ovf_err8",   128'(err),         128'(0));
            end
        end
        chk("ovf_code",  128'(err_code),    128'(4));
        chk("ovf_count", 128'(layer_count), 128'(8));

        // BGRAD operand captured in the commit cycle
        do_reset();
        cmd(ASN_LAYER, '0);
        cmd(ASN_SCRATCH, '0);
        cmd(ASN_SGRAD, mh(10, 18));
        cmd(ASN_BGRAD, mh(18, 26));
        cmd(ASN_MODEL, mh(87, 95));
        rd(3'd0, 3'd5);
        chk("bg_count",   128'(layer_count), 128'(1));
        chk("bg_present", 128'(rd_present),  128'(6'b100011));
        chk("bg_region",  128'(rd_region),   128'(mh(87, 95)));
        chk("bg_err",     128'(err),         128'(0));

`ifdef ASN_RANGE_CHECK_EN
        do_reset();
        cmd(ASN_LAYER, '0);
        cmd(ASN_SCRATCH, '0);
        cmd(WAIT, mh(50, 42));
        chk("range_code", 128'(err_code), 128'(5));
`endif

        // asynchronous reset in the middle of a layer
        do_reset();
        cmd(ASN_LAYER, '0);
        cmd(ASN_SCRATCH, '0);
        cmd(ASN_SGRAD, mh(1, 2));
        cmd(ASN_MODEL, mh(2, 3));
        cmd(ASN_INPUT, '0);
        cmd(ASN_OUTPUT, mh(4, 5));
        cmd(WAIT, mh(5, 6));
        cmd(ASN_LAYER, '0);
        cmd(ASN_LAYER, '0);
        cmd(ASN_SCRATCH, '0);
        chk("pre_rst_valid", 128'(model_valid), 128'(1));
        #2;
        mm_o = WAIT;
        rst_l = 1'b0;
        #1;
        chk("mid_rst_count",  128'(layer_count), 128'(0));
        chk("mid_rst_err",    128'(err),         128'(0));
        chk("mid_rst_valid",  128'(model_valid), 128'(0));
        chk("mid_rst_in",     128'(in_region),   128'(0));
        chk("mid_rst_rdpres", 128'(rd_present),  128'(0));
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        cmd(ASN_MODEL, mh(9, 9));
        chk("post_rst_count", 128'(layer_count), 128'(0));

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            mm_state     c;
            mem_handle_t p;
            bit          clr;
            r = $urandom_range(0, 99);
            if (r < 8)       c = ASN_LAYER;
            else if (r < 14) c = WAIT;
            else if (r < 24) c = ASN_MODEL;
            else if (r < 30) c = ASN_INPUT;
            else if (r < 36) c = ASN_OUTPUT;
            else             c = mm_state'(4'($urandom_range(2, 7)));
            clr = ($urandom_range(0, 99) < 2);
            p.region_begin = ADDR_W'($urandom);
            if ($urandom_range(0, 1) == 1)
                p.region_end = p.region_begin + ADDR_W'($urandom_range(0, 255));
            else
                p.region_end = ADDR_W'($urandom);
            cycle(clr, c, layer_opcode'(3'($urandom_range(0, 4))), p,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/asn_table_rx.md
# asn_table_rx

Receive-side decoder for the DPR→model_manager assignment protocol (`mm_o`, `asn_opcode`, `dpr_pass`). It watches the assignment stream, builds a per-layer region table plus the model input and output regions, and flags protocol violations. It is used as a bus monitor and scoreboard beside model_manager, and as the table front-end for later manager revisions. It is a passive listener and never back-pressures the DPR.

## Interface
Parameters:
- `MAX_LAYERS`, 8: number of table entries; `layer_count` is `$clog2(MAX_LAYERS+1)` bits.
- `ADDR_SIZE`, `` `ADDR_SIZE ``: width of `region_begin` and `region_end`. The MSB selects the address space.

Ports:
- `clk` in 1: the block's only clock.
- `rst_l` in 1: reset, asynchronous and active-low.
- `mm_o` in `mm_state`: assignment command for this cycle.
- `asn_opcode` in `layer_opcode`: layer opcode, sampled on `ASN_LAYER`.
- `dpr_pass` in `mem_handle_t`: region operand. It belongs to the command issued on the previous cycle.
- `tbl_clr` in 1: synchronous clear of all state.
- `rd_idx` in `$clog2(MAX_LAYERS)`: table read index.
- `rd_sel` in 3: region select. 0=SCRATCH, 1=SGRAD, 2=WEIGHT, 3=WGRAD, 4=BIAS, 5=BGRAD.
- `rd_region` out `mem_handle_t`: selected region, registered.
- `rd_opcode` out `layer_opcode`: opcode of entry `rd_idx`, registered.
- `rd_present` out 6: mask of the regions written in entry `rd_idx`, registered.
- `layer_count` out: number of committed layers.
- `in_region`, `out_region` out `mem_handle_t`: model input and output regions.
- `model_valid` out 1: model fully described.
- `err` out 1: sticky protocol error.
- `err_code` out 3: code of the first error seen.

## Operation
- Layer state is either IDLE (no layer open) or OPEN (a layer is being assembled in the staging record).
- `WAIT`: no effect.
- `ASN_LAYER`:
  - From IDLE: go to OPEN, clear staging, latch `asn_opcode`.
  - From OPEN: error 1 (nested layer). Staging is discarded and reopened with the new opcode.
- Pointer commands (`ASN_SCRATCH`, `ASN_SGRAD`, `ASN_WEIGHT`, `ASN_WGRAD`, `ASN_BIAS`, `ASN_BGRAD`, `ASN_INPUT`, `ASN_OUTPUT`):
  - The command loads a one-entry pending register with its kind.
  - On the next cycle `dpr_pass` is captured into the matching staging slot, or into `in_region`/`out_region`, and the slot's present bit is set.
  - The `mm_o` of that capture cycle is decoded in the same cycle, so back-to-back pointer commands run at one per cycle.
- A layer pointer command issued in IDLE: error 2. Its operand is dropped.
- `ASN_MODEL`:
  - From OPEN: commit staging to entry `layer_count`, increment `layer_count`, go to IDLE.
  - From IDLE: no-op.
  - If SCRATCH or SGRAD is absent at commit: error 3. The layer is still committed.
  - If the table already holds `MAX_LAYERS` layers: error 4. The commit is dropped and `layer_count` saturates.
- Same-cycle capture and commit: a capture lands in staging before the commit, so the committed layer includes it.
- `model_valid` asserts when `in_region` and `out_region` have both been captured, `layer_count` > 0, and the state is IDLE. It stays high until `tbl_clr` or reset.
- `err`/`err_code` hold the first error until `tbl_clr` or reset. Later errors are ignored.
- `tbl_clr` has priority over every command and drops any pending capture.

## Timing
- Reset and `tbl_clr` values:
  - All outputs 0; `layer_count`=0.
  - State IDLE, pending register empty.
  - Table present masks 0. Table region contents are don't-care.
- Capture latency: command on cycle N, operand sampled at the end of cycle N+1, visible in `in_region`/`out_region` or staging at N+2.
- Commit latency: `ASN_MODEL` at cycle N makes `layer_count` update at N+1.
- Read latency: `rd_*` outputs reflect `rd_idx`/`rd_sel` with 1 cycle of latency.
- Reading an uncommitted index returns `rd_present`=0.
- Reset asserted mid-stream aborts at once. Staging is lost and no partial commit occurs.

## Configuration
- `ASN_RANGE_CHECK_EN` defined:
  - Every capture checks `region_end >= region_begin`, and that the MSBs of `region_begin` and `region_end` are equal.
  - A failed check raises error 5. The region is still stored.
- Not defined: no range logic is built and error 5 never occurs.

## Test plan
- Full model:
  - Stimulus: LINEAR layer with SCRATCH 42–50, SGRAD 50–58, WEIGHT 5–34, WGRAD 58–87, BIAS 34–42, BGRAD 87–95, then `ASN_MODEL`. RELU layer with 95–103 / 103–111, then `ASN_MODEL`. MSE layer with 111–119 / 119–127, then `ASN_MODEL`. Then INPUT 0x8000_0000–7 and OUTPUT 7–14, both in space 1.
  - Required: `layer_count`=3, entry 0 WEIGHT=5..34, entry 1 `rd_present`=6'b000011, `model_valid`=1, `err`=0.
- `ASN_LAYER` issued twice without `ASN_MODEL` → `err`=1, `err_code`=1, and the second opcode is kept.
- `ASN_WEIGHT` issued in IDLE → `err_code`=2, and `layer_count` is unchanged.
- Commit of the 9th layer with `MAX_LAYERS`=8 → `err_code`=4 and `layer_count` stays at 8.
- `ASN_BGRAD` on cycle N, then `ASN_MODEL` on N+1 with its operand 87–95 → the committed entry has BGRAD present with value 87–95.
- With `ASN_RANGE_CHECK_EN` defined, SCRATCH 50–42 → `err_code`=5. Reset asserted mid-layer → all outputs 0 and `layer_count`=0.
